// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Each operation takes a fixed W+2 clocks: one latch cycle, W radix-2 iterations on
// operand magnitudes, then one sign fix-up cycle that writes HI/LO.
// Ports:
//   clk_87, rst_87            clock, asynchronous active-high reset
//   start_87, op_87           request strobe (IDLE only), op 00 MULT 01 MULTU 10 DIV 11 DIVU
//   arg_a_87, arg_b_87        rs / rt operands, sampled with start_87
//   wr_hi_87, wr_lo_87        MTHI / MTLO strobes (IDLE only), data on wr_data_87
//   busy_87, done_87          operation in progress / one-cycle completion pulse
//   div_zero_87               divide by zero, valid with done_87
//   hi_87, lo_87              architectural HI / LO
module mult_div_unit #(
    parameter int unsigned W = 32
) (
    input  logic         clk_87,
    input  logic         rst_87,
    input  logic         start_87,
    input  logic [1:0]   op_87,
    input  logic [W-1:0] arg_a_87,
    input  logic [W-1:0] arg_b_87,
    input  logic         wr_hi_87,
    input  logic         wr_lo_87,
    input  logic [W-1:0] wr_data_87,
    output logic         busy_87,
    output logic         done_87,
    output logic         div_zero_87,
    output logic [W-1:0] hi_87,
    output logic [W-1:0] lo_87
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned W2    = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_signed;
    logic             r_psign;     // product / quotient sign
    logic             r_rsign;     // remainder sign
    logic             r_dz;
    logic [W-1:0]     r_orig_a;
    logic [W-1:0]     r_opnd;      // multiplicand or divisor magnitude
    logic [W2-1:0]    r_acc;       // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic             r_busy;
    logic             r_done;
    logic             r_dz_out;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic [W-1:0]  w_abs_a;
    logic [W-1:0]  w_abs_b;
    logic [W:0]    w_sum;
    logic [W2-1:0] w_mul_next;
    logic [W:0]    w_trial;
    logic [W-1:0]  w_diff;
    logic          w_ge;
    logic [W2-1:0] w_div_next;
    logic [W2-1:0] w_prod;
    logic [W-1:0]  w_quo;
    logic [W-1:0]  w_rem;
    logic [W-1:0]  w_fix_hi;
    logic [W-1:0]  w_fix_lo;

    // Operand magnitudes; only signed ops (op[0]=0) take the absolute value.
    always_comb begin
        w_abs_a = arg_a_87;
        w_abs_b = arg_b_87;
        if (!op_87[0] && arg_a_87[W-1]) w_abs_a = ~arg_a_87 + W'(1);
        if (!op_87[0] && arg_b_87[W-1]) w_abs_b = ~arg_b_87 + W'(1);
    end

    // One shift-add step; the carry rides in the extra sum bit so nothing is lost.
    always_comb begin
        w_sum      = {1'b0, r_acc[W2-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_mul_next = {w_sum, r_acc[W-1:1]};
    end

    // One restoring-divide step; the remainder stays below the divisor so W bits hold it.
    always_comb begin
        w_trial    = {r_acc[W2-1:W], r_acc[W-1]};
        w_ge       = (w_trial >= {1'b0, r_opnd});
        w_diff     = w_trial[W-1:0] - r_opnd;
        w_div_next = {(w_ge ? w_diff : w_trial[W-1:0]), r_acc[W-2:0], w_ge};
    end

    // Sign fix-up and final HI/LO selection.
    always_comb begin
        w_prod = r_acc;
        w_quo  = r_acc[W-1:0];
        w_rem  = r_acc[W2-1:W];
        if (r_signed && r_psign) begin
            w_prod = ~r_acc + W2'(1);
            w_quo  = ~r_acc[W-1:0] + W'(1);
        end
        if (r_signed && r_rsign) w_rem = ~r_acc[W2-1:W] + W'(1);
        w_fix_hi = w_prod[W2-1:W];
        w_fix_lo = w_prod[W-1:0];
        if (r_is_div) begin
            w_fix_hi = r_dz ? r_orig_a : w_rem;
            w_fix_lo = r_dz ? {W{1'b1}} : w_quo;
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_psign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_dz     <= 1'b0;
            r_orig_a <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_hi_87) r_hi <= wr_data_87;
                    if (wr_lo_87) r_lo <= wr_data_87;
                    if (start_87) begin
                        r_is_div <= op_87[1];
                        r_signed <= ~op_87[0];
                        r_psign  <= arg_a_87[W-1] ^ arg_b_87[W-1];
                        r_rsign  <= arg_a_87[W-1];
                        r_dz     <= op_87[1] && (arg_b_87 == '0);
                        r_orig_a <= arg_a_87;
                        r_opnd   <= op_87[1] ? w_abs_b : w_abs_a;
                        r_acc    <= {{W{1'b0}}, (op_87[1] ? w_abs_a : w_abs_b)};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(W - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi     <= w_fix_hi;
                    r_lo     <= w_fix_lo;
                    r_done   <= 1'b1;
                    r_dz_out <= r_is_div && r_dz;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_87     = r_busy;
    assign done_87     = r_done;
    assign div_zero_87 = r_dz_out;
    assign hi_87       = r_hi;
    assign lo_87       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: scoreboard of expected HI/LO/div_zero per issued op,
// popped by a monitor on every done_87 pulse, plus directed timing/side-port/reset checks.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clk_87 = 1'b0;
    logic         rst_87 = 1'b1;
    logic         start_87 = 1'b0;
    logic [1:0]   op_87 = 2'b00;
    logic [W-1:0] arg_a_87 = '0;
    logic [W-1:0] arg_b_87 = '0;
    logic         wr_hi_87 = 1'b0;
    logic         wr_lo_87 = 1'b0;
    logic [W-1:0] wr_data_87 = '0;
    logic         busy_87;
    logic         done_87;
    logic         div_zero_87;
    logic [W-1:0] hi_87;
    logic [W-1:0] lo_87;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    mult_div_unit #(.W(W)) dut (
        .clk_87     (clk_87),
        .rst_87     (rst_87),
        .start_87   (start_87),
        .op_87      (op_87),
        .arg_a_87   (arg_a_87),
        .arg_b_87   (arg_b_87),
        .wr_hi_87   (wr_hi_87),
        .wr_lo_87   (wr_lo_87),
        .wr_data_87 (wr_data_87),
        .busy_87    (busy_87),
        .done_87    (done_87),
        .div_zero_87(div_zero_87),
        .hi_87      (hi_87),
        .lo_87      (lo_87)
    );

    always #5 clk_87 = ~clk_87;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                p = 64'(sa * sbv);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (op == 2'b10) begin
                    e.lo = 32'(sa / sbv);
                    e.hi = 32'(sa % sbv);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_87) begin
        if (!rst_87) begin
            if (done_87) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with hi=%h lo=%h, want no completion", hi_87, lo_87);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_hi", 64'(hi_87), 64'(mon_e.hi));
                    check("result_lo", 64'(lo_87), 64'(mon_e.lo));
                    check("result_div_zero", 64'(div_zero_87), 64'(mon_e.dz));
                end
            end else if (div_zero_87) begin
                n_bad++;
                $display("FAIL div_zero_without_done: got 1 want 0");
            end
        end
    end

    // Returns on a negedge with busy low, or flags a timeout.
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy_87) return;
            @(negedge clk_87);
        end
        n_vec++;
        n_bad++;
        $display("FAIL idle_timeout: got busy=1 after 100 cycles want 0");
    endtask

    // Presents one request at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        start_87 = 1'b1;
        op_87    = op;
        arg_a_87 = a;
        arg_b_87 = b;
        sb.push_back(model(op, a, b));
        @(posedge clk_87);
        @(negedge clk_87);
        start_87 = 1'b0;
    endtask

    // Called right after issue(): counts busy cycles and clocks until done.
    task automatic measure(input int exp_lat, input int exp_busy);
        int busy_cnt;
        int lat;
        busy_cnt = 0;
        lat      = -1;
        for (int i = 1; i <= 60; i++) begin
            if (busy_87) busy_cnt++;
            if (done_87) begin
                lat = i;
                break;
            end
            @(negedge clk_87);
        end
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk_87);
        check("reset_busy", 64'(busy_87), 64'd0);
        check("reset_done", 64'(done_87), 64'd0);
        check("reset_div_zero", 64'(div_zero_87), 64'd0);
        check("reset_hi", 64'(hi_87), 64'd0);
        check("reset_lo", 64'(lo_87), 64'd0);
        rst_87 = 1'b0;
        @(negedge clk_87);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        measure(34, 33);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b11, 32'd100, 32'd7);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'h0000_1234, 32'd0);
        issue(2'b10, 32'hFFFF_FF00, 32'd0);
        issue(2'b01, 32'd7, 32'd9);

        // Start and MTHI while busy are dropped.
        issue(2'b01, 32'd5, 32'd6);
        repeat (4) @(negedge clk_87);
        start_87   = 1'b1;
        op_87      = 2'b11;
        arg_a_87   = 32'd9;
        arg_b_87   = 32'd3;
        wr_hi_87   = 1'b1;
        wr_data_87 = 32'h0000_DEAD;
        @(negedge clk_87);
        start_87 = 1'b0;
        wr_hi_87 = 1'b0;
        wait_idle();
        check("busy_write_ignored_hi", 64'(hi_87), 64'd0);
        wr_lo_87   = 1'b1;
        wr_data_87 = 32'h0000_BEEF;
        @(negedge clk_87);
        wr_lo_87 = 1'b0;
        check("mtlo_lo", 64'(lo_87), 64'h0000_BEEF);
        check("mtlo_hi_kept", 64'(hi_87), 64'd0);

        // MTHI+MTLO coinciding with an accepted start still write.
        wait_idle();
        start_87   = 1'b1;
        op_87      = 2'b01;
        arg_a_87   = 32'd3;
        arg_b_87   = 32'd4;
        wr_hi_87   = 1'b1;
        wr_lo_87   = 1'b1;
        wr_data_87 = 32'h0000_A5A5;
        sb.push_back(model(2'b01, 32'd3, 32'd4));
        @(posedge clk_87);
        @(negedge clk_87);
        start_87 = 1'b0;
        wr_hi_87 = 1'b0;
        wr_lo_87 = 1'b0;
        check("start_write_hi", 64'(hi_87), 64'h0000_A5A5);
        check("start_write_lo", 64'(lo_87), 64'h0000_A5A5);
        wait_idle();

        // Asynchronous reset in the middle of a divide.
        issue(2'b10, 32'hFFFF_FF9C, 32'd7);
        repeat (9) @(negedge clk_87);
        #2;
        rst_87 = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy_87), 64'd0);
        check("async_rst_done", 64'(done_87), 64'd0);
        check("async_rst_hi", 64'(hi_87), 64'd0);
        check("async_rst_lo", 64'(lo_87), 64'd0);
        sb.delete();
        @(negedge clk_87);
        rst_87 = 1'b0;
        @(negedge clk_87);
        issue(2'b01, 32'd2, 32'd3);
        measure(34, 33);

        for (int n = 0; n < 150; n++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
        end

        wait_idle();
        repeat (3) @(negedge clk_87);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
